// File: rtl/arf_pkg.sv
// arf_pkg: shared constants and buffer state type for the ARF operand loader.
package arf_pkg;
  localparam int N_OPS = 24;
  localparam int IDX_W = 5;
  localparam int COEF_BASE = 16;
  localparam int COEF2_BASE = 20;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_t;
endpackage

// File: rtl/arf_frame_buf.sv
// arf_frame_buf: one frame register bank, written one word at a time, read flattened.
module arf_frame_buf
  import arf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [W-1:0]         wdata,
  output logic [N_OPS*W-1:0]   rdata
);
  logic [N_OPS-1:0][W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we && idx < IDX_W'(N_OPS)) mem_d[idx] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else mem_q <= mem_d;
  end
  assign rdata = mem_q;
endmodule

// File: rtl/arf_operand_loader.sv
// arf_operand_loader: ping-pong collector of 24-word ARF operand frames with
// valid/ready output, framing-error detection and delivery/error counters.
module arf_operand_loader
  import arf_pkg::*;
#(
  parameter int W = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [W-1:0]         s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N_OPS*W-1:0]   m_data,
  output logic                 err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [7:0]           err_cnt
);
  buf_state_t st_q [2];
  buf_state_t st_d [2];
  logic wsel_q, wsel_d, rsel_q, rsel_d, err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic [7:0] ec_q, ec_d;
  logic [N_OPS*W-1:0] rd0, rd1;
  logic acc, hs, at_end, done, ferr;
  assign s_ready = st_q[wsel_q] != FULL;
  assign m_valid = st_q[rsel_q] == FULL;
  assign m_data = rsel_q ? rd1 : rd0;
  assign acc = s_valid && s_ready;
  assign hs = m_valid && m_ready;
  assign at_end = idx_q == IDX_W'(N_OPS - 1);
  assign done = acc && s_last && at_end;
  assign ferr = acc && (s_last != at_end);
  assign err = err_q;
  assign frame_cnt = fc_q;
  assign err_cnt = ec_q;
  // Read and write sides can never target the same buffer in one cycle:
  // the read side needs FULL, the write side needs not-FULL.
  always_comb begin
    st_d = st_q;
    for (int b = 0; b < 2; b++) begin
      if (hs && rsel_q == 1'(b)) st_d[b] = EMPTY;
      if (acc && wsel_q == 1'(b)) st_d[b] = ferr ? EMPTY : done ? FULL : FILLING;
    end
    idx_d = (done || ferr) ? '0 : acc ? idx_q + 1'b1 : idx_q;
    wsel_d = wsel_q ^ done;
    rsel_d = rsel_q ^ hs;
    err_d = ferr;
    fc_d = fc_q + CNT_W'(hs);
    ec_d = (ferr && ec_q != 8'hff) ? ec_q + 8'd1 : ec_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
      fc_q <= '0;
      ec_q <= '0;
    end else begin
      st_q <= st_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      idx_q <= idx_d;
      err_q <= err_d;
      fc_q <= fc_d;
      ec_q <= ec_d;
    end
  end
  arf_frame_buf #(.W(W)) u_buf0 (
    .clk(clk), .rst_n(rst_n), .we(acc && !wsel_q), .idx(idx_q), .wdata(s_data), .rdata(rd0)
  );
  arf_frame_buf #(.W(W)) u_buf1 (
    .clk(clk), .rst_n(rst_n), .we(acc && wsel_q), .idx(idx_q), .wdata(s_data), .rdata(rd1)
  );
endmodule

// File: doc/arf_operand_loader.md
Name: arf_operand_loader

Overview:
- Upstream stage of the ARF datapath. Collects a serial stream of operand words into one complete ARF operand frame and presents it with a valid/ready handshake.
- A frame is 24 words: 16 first-stage multiplier operands plus 8 coefficients for multipliers 15-18 and 21-24.
- Double-buffered (ping-pong), so the next frame loads while the datapath holds the current one.

Parameters:
- W, 16, width of one operand word in bits.
- CNT_W, 16, width of the delivered-frame counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  W  operand word.
- s_last  in  1  marks final word of a frame.
- m_valid  out  1  complete frame available.
- m_ready  in  1  datapath accepts the frame.
- m_data  out  24*W  frame; word k at bits [k*W +: W].
- err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  CNT_W  frames delivered (m_valid && m_ready), wraps at 2^CNT_W.
- err_cnt  out  8  framing errors, saturates at 255.

Behaviour:
- Word map:
  - k=0..15 -> in_{k/2+1}_{k%2}.
  - k=16..19 -> in_{k-1}_1 (coefficients for multipliers 15-18).
  - k=20..23 -> in_{k+1}_1 (coefficients for multipliers 21-24).
- Reset (asynchronous, rst_n=0):
  - Both buffers EMPTY, wsel=0, rsel=0, idx=0, buffer contents 0.
  - Outputs: m_valid=0, s_ready=1 (after reset release), err=0, frame_cnt=0, err_cnt=0, m_data=0.
- Buffer state: each buffer is EMPTY, FILLING or FULL.
  - EMPTY -> FILLING: first word accepted into it.
  - FILLING -> FULL: word with idx=23 and s_last=1 accepted.
  - FULL -> EMPTY: handshake (m_valid && m_ready) on it.
- Input side:
  - s_ready = (buffer[wsel] != FULL).
  - Accept = s_valid && s_ready; the word is written to buffer[wsel] slot idx.
  - On completion: idx<=0, wsel toggles.
- Output side:
  - m_valid = (buffer[rsel] == FULL).
  - m_data is driven directly from buffer[rsel] registers; no combinational path from s_data.
  - On handshake: rsel toggles and frame_cnt increments.
- Latency: last word accepted in cycle N -> m_valid=1 in cycle N+1 when no other frame is pending.
- Throughput: one word per cycle sustained while m_ready keeps up. A full frame at the output never stalls input until the second buffer is also FULL.
- Framing errors:
  - s_last=1 accepted at idx<23, or idx=23 accepted with s_last=0.
  - The word is consumed. err pulses one cycle and err_cnt increments (saturating).
  - idx<=0; buffer[wsel] returns to EMPTY; wsel is unchanged.
  - A partial frame is never presented.
- Simultaneous events:
  - Completion on buffer X and handshake on buffer Y in the same cycle are both applied.
  - When both buffers are FULL, s_ready=0. A handshake that cycle frees buffer[rsel], and s_ready rises the next cycle.
- m_data and m_valid are stable while m_valid=1 && m_ready=0.
- Reset mid-frame discards all buffered data; no spurious m_valid or err after release.

Decomposition:
- Package arf_pkg:
  - localparam N_OPS=24, IDX_W=5.
  - typedef enum buf_state_t {EMPTY, FILLING, FULL}.
  - Word-index constants COEF_BASE=16 and COEF2_BASE=20.
- Sub-module arf_frame_buf: one 24xW register bank with write-enable and index input and a flattened read output. Instantiated twice.
- The top level holds the idx counter, wsel/rsel, the per-buffer state, the error logic and the counters.

Test Plan:
- Reset, send words 1..24 (s_last on 24th), m_ready=1 -> m_valid the cycle after word 24; word k = k+1; frame_cnt=1; err never set.
- Three back-to-back frames, m_ready=0 -> s_ready falls after frame 2 completes. Then m_ready=1 -> frames delivered in order and frame_cnt=3.
- s_last on 10th word -> err pulse, err_cnt=1, no m_valid. The next clean 24-word frame is delivered intact.
- 24th word with s_last=0 -> err=1, idx resets; 25th word treated as slot 0 of a new frame.
- rst_n low mid-frame (after 12 words) -> outputs at reset values. A following full frame is delivered correctly.
- 256 consecutive framing errors -> err_cnt holds at 255.
